// File: rtl/channel_sched.sv
// channel_sched: frame scheduler for the channel waveform units.
// A frame request (ram_wr_done_i) starts every enabled channel at once, the
// block then waits for a done pulse from each enabled channel, and finally
// holds a programmable latch interval before the frame is reported complete.
// Requests arriving while a frame is in flight collapse into one pending frame.
module channel_sched #(
    parameter int CHAN_NUM = 16,
    parameter int LATCH_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ram_wr_done_i,
    input  logic [3:0]          reg_chan_cnt_i,
    input  logic [LATCH_W-1:0]  latch_cyc_i,
    input  logic [CHAN_NUM-1:0] chan_done_i,
    output logic [CHAN_NUM-1:0] chan_start_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic [7:0]          frame_cnt_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                pend;
    logic [CHAN_NUM-1:0] en_mask;
    logic [CHAN_NUM-1:0] done_mask;
    logic [CHAN_NUM-1:0] done_hit;
    logic [LATCH_W-1:0]  latch_cnt;
    logic                frame_req;
    logic                all_done;
    logic                latch_end;
    logic                wait_exit;

    // Lowest (cnt+1) channels enabled; anything beyond CHAN_NUM is clipped.
    function automatic logic [CHAN_NUM-1:0] chan_mask(input logic [3:0] cnt);
        logic [CHAN_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < CHAN_NUM; i++) begin
            m[i] = (i <= int'(cnt));
        end
        return m;
    endfunction

    // Qualify done pulses against the snapshot mask and decode frame events.
    always_comb begin
        frame_req = ram_wr_done_i | pend;
        done_hit  = chan_done_i & en_mask;
        all_done  = ((done_mask | done_hit) == en_mask);
        wait_exit = (state == WAIT) && all_done;
        latch_end = (state == LATCH) && (latch_cnt == '0);
    end

    // Next-state decode of the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_req) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (all_done) state_nxt = LATCH;
            LATCH:   if (latch_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; busy tracks the registered state so it has no input path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != IDLE);
        end
    end

    // Channel enable snapshot, taken only when a frame is launched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_mask <= '0;
        end else if ((state == IDLE) && frame_req) begin
            en_mask <= chan_mask(reg_chan_cnt_i);
        end
    end

    // Start pulse is high for exactly the START cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chan_start_o <= '0;
        end else if ((state == IDLE) && frame_req) begin
            chan_start_o <= chan_mask(reg_chan_cnt_i);
        end else begin
            chan_start_o <= '0;
        end
    end

    // Accumulate done pulses while waiting; repeats and disabled channels fall out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_mask <= '0;
        end else if (state == START) begin
            done_mask <= '0;
        end else if (state == WAIT) begin
            done_mask <= done_mask | done_hit;
        end
    end

    // A request seen outside IDLE is remembered; a set in START beats the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= 1'b0;
        end else if ((state != IDLE) && ram_wr_done_i) begin
            pend <= 1'b1;
        end else if (state == START) begin
            pend <= 1'b0;
        end
    end

    // Latch interval counter: loaded on WAIT exit, counts down to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latch_cnt <= '0;
        end else if (wait_exit) begin
            latch_cnt <= latch_cyc_i;
        end else if ((state == LATCH) && (latch_cnt != '0)) begin
            latch_cnt <= latch_cnt - LATCH_W'(1);
        end
    end

    // Frame done is raised one cycle early so it lines up with the final LATCH cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= (wait_exit && (latch_cyc_i == '0)) ||
                            ((state == LATCH) && (latch_cnt == LATCH_W'(1)));
        end
    end

    // Completed-frame counter, naturally wrapping at 8 bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_o <= '0;
        end else if (latch_end) begin
            frame_cnt_o <= frame_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_channel_sched.sv
// Testbench for channel_sched: table-driven frames, pending-request and
// reset-abort sequences, and frame counter wrap. Start masks are checked
// through a scoreboard queue filled when each frame is requested.
module tb_channel_sched;

    logic        clk;
    logic        rst;
    logic        ram_wr_done;
    logic [3:0]  reg_chan_cnt;
    logic [15:0] latch_cyc;
    logic [15:0] chan_done;
    logic [15:0] chan_start;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_fc = 8'd0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [3:0]  cnt;
        logic [15:0] latch;
        logic [15:0] done_a;
        logic [15:0] done_b;
        logic [15:0] exp_start;
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    channel_sched #(.CHAN_NUM(16), .LATCH_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ram_wr_done_i  (ram_wr_done),
        .reg_chan_cnt_i (reg_chan_cnt),
        .latch_cyc_i    (latch_cyc),
        .chan_done_i    (chan_done),
        .chan_start_o   (chan_start),
        .busy_o         (busy),
        .frame_done_o   (frame_done),
        .frame_cnt_o    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: every observed start pulse must match the next expected mask.
    initial begin
        logic [15:0] m;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && chan_start !== 16'h0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: got 0x%0h expected no start", chan_start);
                end else begin
                    m = sb_q.pop_front();
                    if (chan_start !== m) begin
                        errors++;
                        $display("FAIL start_mask: got 0x%0h expected 0x%0h", chan_start, m);
                    end
                end
            end
        end
    end

    // Called in the first LATCH cycle; returns at the following IDLE cycle.
    task automatic measure_latch(input int exp_len, input string tag);
        int n;
        int fd;
        int fd_pos;
        n = 0;
        fd = 0;
        fd_pos = -1;
        while (busy === 1'b1 && n < 200) begin
            if (frame_done === 1'b1) begin
                fd++;
                fd_pos = n;
            end
            n++;
            tick();
        end
        exp_fc = exp_fc + 8'd1;
        check({tag, "_latch_len"}, n, exp_len);
        check({tag, "_frame_done_count"}, fd, 1);
        check({tag, "_frame_done_pos"}, fd_pos, exp_len - 1);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
        check({tag, "_idle_no_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic wait_frame_done(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_frame_done_seen"}, 32'(frame_done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cnt: 4'd7,  latch: 16'd10, done_a: 16'h000F, done_b: 16'h00F0, exp_start: 16'h00FF, exp_len: 11};
        vecs[1] = '{cnt: 4'd0,  latch: 16'd3,  done_a: 16'h0020, done_b: 16'h0001, exp_start: 16'h0001, exp_len: 4};
        vecs[2] = '{cnt: 4'd15, latch: 16'd0,  done_a: 16'h0000, done_b: 16'hFFFF, exp_start: 16'hFFFF, exp_len: 1};
        vecs[3] = '{cnt: 4'd3,  latch: 16'd2,  done_a: 16'hFFF7, done_b: 16'h0008, exp_start: 16'h000F, exp_len: 3};
        vecs[4] = '{cnt: 4'd9,  latch: 16'd5,  done_a: 16'h01FF, done_b: 16'h0200, exp_start: 16'h03FF, exp_len: 6};

        rst = 1'b1;
        ram_wr_done = 1'b0;
        reg_chan_cnt = 4'd0;
        latch_cyc = 16'd0;
        chan_done = 16'h0;
        tick();
        tick();
        check("reset_start", 32'(chan_start), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        rst = 1'b0;
        tick();

        // Table-driven single frames
        for (int k = 0; k < 5; k++) begin
            reg_chan_cnt = vecs[k].cnt;
            latch_cyc = vecs[k].latch;
            sb_q.push_back(vecs[k].exp_start);
            ram_wr_done = 1'b1;
            tick();
            ram_wr_done = 1'b0;
            check("vec_start_latency", 32'(chan_start != 16'h0), 1);
            check("vec_busy_in_start", 32'(busy), 1);
            chan_done = 16'hFFFF;
            reg_chan_cnt = ~vecs[k].cnt;
            latch_cyc = 16'd999;
            tick();
            chan_done = 16'h0;
            check("vec_start_one_cycle", 32'(chan_start), 0);
            chan_done = vecs[k].done_a;
            tick();
            chan_done = 16'h0;
            tick();
            check("vec_wait_busy", 32'(busy), 1);
            check("vec_wait_no_frame_done", 32'(frame_done), 0);
            chan_done = vecs[k].done_b;
            latch_cyc = vecs[k].latch;
            tick();
            chan_done = 16'h0;
            latch_cyc = 16'd999;
            measure_latch(vecs[k].exp_len, "vec");
        end

        // Several requests during WAIT collapse into one extra frame, and a
        // request on the final LATCH cycle is still captured.
        reg_chan_cnt = 4'd1;
        latch_cyc = 16'd2;
        sb_q.push_back(16'h0003);
        sb_q.push_back(16'h0003);
        sb_q.push_back(16'h0003);
        ram_wr_done = 1'b1;
        tick();
        ram_wr_done = 1'b0;
        check("pend_start_latency", 32'(chan_start != 16'h0), 1);
        tick();
        repeat (3) begin
            ram_wr_done = 1'b1;
            tick();
            ram_wr_done = 1'b0;
            tick();
        end
        check("pend_wait_busy", 32'(busy), 1);
        chan_done = 16'h0003;
        tick();
        chan_done = 16'h0;
        measure_latch(3, "pend1");
        tick();
        check("pend_second_start", 32'(chan_start != 16'h0), 1);
        check("pend_second_busy", 32'(busy), 1);
        tick();
        chan_done = 16'h0001;
        tick();
        chan_done = 16'h0002;
        tick();
        chan_done = 16'h0;
        wait_frame_done("pend2");
        ram_wr_done = 1'b1;
        tick();
        ram_wr_done = 1'b0;
        exp_fc = exp_fc + 8'd1;
        check("pend2_idle_busy", 32'(busy), 0);
        check("pend2_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        tick();
        check("pend_third_start", 32'(chan_start != 16'h0), 1);
        tick();
        chan_done = 16'h0003;
        tick();
        chan_done = 16'h0;
        measure_latch(3, "pend3");
        repeat (8) tick();
        check("pend_no_fourth_frame", 32'(busy), 0);

        // Reset in WAIT with a pending request aborts everything.
        reg_chan_cnt = 4'd2;
        latch_cyc = 16'd1;
        sb_q.push_back(16'h0007);
        ram_wr_done = 1'b1;
        tick();
        ram_wr_done = 1'b0;
        tick();
        ram_wr_done = 1'b1;
        tick();
        ram_wr_done = 1'b0;
        chan_done = 16'h0001;
        tick();
        chan_done = 16'h0;
        check("abort_pre_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_start", 32'(chan_start), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_frame_done", 32'(frame_done), 0);
        check("abort_frame_cnt", 32'(frame_cnt), 0);
        exp_fc = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("abort_pend_lost", 32'(busy), 0);
        sb_q.push_back(16'h0007);
        ram_wr_done = 1'b1;
        tick();
        ram_wr_done = 1'b0;
        check("abort_new_start", 32'(chan_start != 16'h0), 1);
        tick();
        chan_done = 16'h0007;
        tick();
        chan_done = 16'h0;
        measure_latch(2, "abort");

        // 256 back-to-back frames: counter wraps to zero on the last one.
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_fc = 8'd0;
        tick();
        reg_chan_cnt = 4'd0;
        latch_cyc = 16'd0;
        for (int f = 1; f <= 256; f++) begin
            sb_q.push_back(16'h0001);
            ram_wr_done = 1'b1;
            tick();
            ram_wr_done = 1'b0;
            tick();
            chan_done = 16'h0001;
            tick();
            chan_done = 16'h0;
            check("wrap_frame_done", 32'(frame_done), 1);
            tick();
            exp_fc = exp_fc + 8'd1;
            check("wrap_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
            if (f == 255) check("wrap_cnt_255", 32'(frame_cnt), 255);
            if (f == 256) check("wrap_cnt_0", 32'(frame_cnt), 0);
        end

        repeat (4) tick();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
